vram_pixel_arbiter: RTL and testbench

- Shares the single-port pixel-plane VRAM (17-bit address, 24-bit RGB word, 1-cycle synchronous read) between the pixel renderer and the CPU memory bus.
- During active video, cycles alternate between renderer slots and CPU slots. The renderer fetches each pixel once and holds it for two clocks, matching 2x horizontal scaling.
- During blanking, every cycle is a CPU slot.
- Sits between the GPU pixel renderer, the CPU bus bridge and the VRAMpixel memory.

---
 rtl/vram_pixel_arbiter_if.sv | 32 +++
 rtl/vram_pixel_arbiter.sv | 106 ++++++++++
 tb/tb_vram_pixel_arbiter.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/vram_pixel_arbiter_if.sv
// Pixel-plane VRAM arbiter bus bundle: renderer port, CPU request port and VRAM port.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface vram_pixel_arbiter_if #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 24
);
  logic              blank;
  logic              line_start;
  logic [ADDR_W-1:0] pe_addr;
  logic [DATA_W-1:0] pe_q;
  logic              cpu_start;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_data;
  logic [DATA_W-1:0] cpu_q;
  logic              cpu_done;
  logic              cpu_busy;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_d;
  logic              ram_we;
  logic [DATA_W-1:0] ram_q;

  modport slave (
    input  blank, line_start, pe_addr, cpu_start, cpu_we, cpu_addr, cpu_data, ram_q,
    output pe_q, cpu_q, cpu_done, cpu_busy, ram_addr, ram_d, ram_we
  );

  modport master (
    output blank, line_start, pe_addr, cpu_start, cpu_we, cpu_addr, cpu_data, ram_q,
    input  pe_q, cpu_q, cpu_done, cpu_busy, ram_addr, ram_d, ram_we
  );
endinterface

// File: rtl/vram_pixel_arbiter.sv
// Time-slices the single-port pixel VRAM between the renderer (even phase of active
// video) and the CPU (odd phase, or every cycle during blanking).
module vram_pixel_arbiter #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  vram_pixel_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    RDCAP = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              phase;
  logic              pix_slot, cpu_slot;
  logic              pix_d;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_data;
  logic              load, cap;
  logic              busy_q;
  logic [DATA_W-1:0] pe_q_r, cpu_q_r;
  logic [ADDR_W-1:0] ram_addr_c;
  logic [DATA_W-1:0] ram_d_c;
  logic              ram_we_c;

  assign pix_slot = !bus.blank && (phase == 1'b0);
  assign cpu_slot =  bus.blank || (phase == 1'b1);

  // ram_we is purely combinational from state_q, so async reset drops it at once.
  always_comb begin
    state_d    = state_q;
    load       = 1'b0;
    cap        = 1'b0;
    ram_addr_c = bus.pe_addr;
    ram_d_c    = lat_data;
    ram_we_c   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.cpu_start) begin
          load    = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cpu_slot) begin
          ram_addr_c = lat_addr;
          ram_we_c   = lat_we;
          state_d    = lat_we ? DONE : RDCAP;
        end
      end
      RDCAP: begin
        cap     = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      phase    <= 1'b0;
      pix_d    <= 1'b0;
      pe_q_r   <= '0;
      cpu_q_r  <= '0;
      busy_q   <= 1'b0;
      lat_we   <= 1'b0;
      lat_addr <= '0;
      lat_data <= '0;
    end else begin
      state_q <= state_d;
      phase   <= bus.line_start ? 1'b0 : ~phase;
      pix_d   <= pix_slot;
      // ram_q in the cycle after a renderer slot belongs to the renderer's address.
      if (pix_d) pe_q_r <= bus.ram_q;
      if (cap)   cpu_q_r <= bus.ram_q;
      if (load) begin
        lat_we   <= bus.cpu_we;
        lat_addr <= bus.cpu_addr;
        lat_data <= bus.cpu_data;
        busy_q   <= 1'b1;
      end else if (state_q == DONE) begin
        busy_q   <= 1'b0;
      end
    end
  end

  assign bus.pe_q     = pe_q_r;
  assign bus.cpu_q    = cpu_q_r;
  assign bus.cpu_done = (state_q == DONE);
  assign bus.cpu_busy = busy_q;
  assign bus.ram_addr = ram_addr_c;
  assign bus.ram_d    = ram_d_c;
  assign bus.ram_we   = ram_we_c;

endmodule

// File: tb/tb_vram_pixel_arbiter.sv
// Directed bench for vram_pixel_arbiter with a behavioural 1-cycle-read VRAM.
module tb_vram_pixel_arbiter;

  localparam int ADDR_W = 17;
  localparam int DATA_W = 24;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  int   we_cnt;
  int   done_cnt;

  vram_pixel_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  vram_pixel_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_d;
    bus.ram_q <= mem[bus.ram_addr];
  end

  always @(posedge clk) begin
    if (!reset && bus.ram_we)   we_cnt   <= we_cnt + 1;
    if (!reset && bus.cpu_done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Issues one request and returns the cycle offset of cpu_done (-1 on timeout).
  task automatic cpu_op(input logic we, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d, output int lat);
    cyc();
    bus.cpu_start = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = a;
    bus.cpu_data  = d;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      bus.cpu_start = 1'b0;
      sample();
      if (bus.cpu_done) begin
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int we0, done0;
    logic [DATA_W-1:0] exp_pix [0:5];

    checks = 0; failures = 0; we_cnt = 0; done_cnt = 0;
    reset = 1'b1;
    bus.blank = 1'b1; bus.line_start = 1'b0; bus.pe_addr = '0;
    bus.cpu_start = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_data = '0;

    // Reset state
    repeat (2) @(posedge clk);
    sample();
    check("rst_ram_we",   32'(bus.ram_we),   32'h0);
    check("rst_cpu_done", 32'(bus.cpu_done), 32'h0);
    check("rst_cpu_busy", 32'(bus.cpu_busy), 32'h0);
    check("rst_pe_q",     32'(bus.pe_q),     32'h0);
    check("rst_cpu_q",    32'(bus.cpu_q),    32'h0);
    cyc();
    reset = 1'b0;

    // Blanking write: exact cycle-by-cycle view
    cyc();
    bus.cpu_start = 1'b1; bus.cpu_we = 1'b1;
    bus.cpu_addr = 17'h00140; bus.cpu_data = 24'hFF8000;
    sample();
    check("w_t0_busy", 32'(bus.cpu_busy), 32'h0);
    cyc();
    bus.cpu_start = 1'b0;
    sample();
    check("w_t1_we",   32'(bus.ram_we),   32'h1);
    check("w_t1_addr", 32'(bus.ram_addr), 32'h00140);
    check("w_t1_d",    32'(bus.ram_d),    32'hFF8000);
    check("w_t1_busy", 32'(bus.cpu_busy), 32'h1);
    check("w_t1_done", 32'(bus.cpu_done), 32'h0);
    cyc();
    sample();
    check("w_t2_done", 32'(bus.cpu_done), 32'h1);
    check("w_t2_busy", 32'(bus.cpu_busy), 32'h1);
    check("w_t2_we",   32'(bus.ram_we),   32'h0);
    cyc();
    sample();
    check("w_t3_busy", 32'(bus.cpu_busy), 32'h0);
    check("w_t3_done", 32'(bus.cpu_done), 32'h0);
    check("w_mem",     32'(mem[17'h00140]), 32'hFF8000);

    // Blanking write then read-back at the top address
    cpu_op(1'b1, 17'h1FFFF, 24'h123456, lat);
    check("wr_top_lat", 32'(lat), 32'd2);
    cpu_op(1'b0, 17'h1FFFF, 24'h000000, lat);
    check("rd_top_lat", 32'(lat), 32'd3);
    check("rd_top_q",   32'(bus.cpu_q), 32'h123456);
    cyc();
    sample();
    check("rd_q_hold",  32'(bus.cpu_q), 32'h123456);

    // Active video: request lands on a renderer slot and waits one cycle
    cyc();
    bus.blank = 1'b0; bus.line_start = 1'b1; bus.pe_addr = 17'h00010;
    bus.cpu_start = 1'b1; bus.cpu_we = 1'b1;
    bus.cpu_addr = 17'h00055; bus.cpu_data = 24'h0ABCDE;
    cyc();
    bus.line_start = 1'b0; bus.cpu_start = 1'b0;
    sample();
    check("av_t1_we",   32'(bus.ram_we),   32'h0);
    check("av_t1_addr", 32'(bus.ram_addr), 32'h00010);
    check("av_t1_busy", 32'(bus.cpu_busy), 32'h1);
    cyc();
    sample();
    check("av_t2_we",   32'(bus.ram_we),   32'h1);
    check("av_t2_addr", 32'(bus.ram_addr), 32'h00055);
    cyc();
    sample();
    check("av_t3_done", 32'(bus.cpu_done), 32'h1);
    check("av_t3_addr", 32'(bus.ram_addr), 32'h00010);
    check("av_t3_we",   32'(bus.ram_we),   32'h0);

    // Renderer pipeline with 2x horizontal scaling
    bus.blank = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cpu_op(1'b1, 17'(i), 24'hA00000 + 24'(i), lat);
    end
    exp_pix[0] = 24'hA00000; exp_pix[1] = 24'hA00000;
    exp_pix[2] = 24'hA00001; exp_pix[3] = 24'hA00001;
    exp_pix[4] = 24'hA00002; exp_pix[5] = 24'hA00002;
    cyc();
    bus.blank = 1'b0; bus.line_start = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      cyc();
      bus.line_start = 1'b0;
      if (c <= 6) bus.pe_addr = 17'((c - 1) / 2);
      sample();
      if (c >= 3) check($sformatf("pix_%0d", c), 32'(bus.pe_q), 32'(exp_pix[c-3]));
    end

    // Repeated cpu_start while busy / in DONE is ignored
    bus.blank = 1'b1;
    cyc();
    we0 = we_cnt; done0 = done_cnt;
    bus.cpu_start = 1'b1; bus.cpu_we = 1'b1;
    bus.cpu_addr = 17'h00200; bus.cpu_data = 24'h00AA55;
    cyc();
    bus.cpu_data = 24'h111111;
    cyc();
    bus.cpu_data = 24'h222222;
    cyc();
    bus.cpu_start = 1'b0;
    repeat (4) cyc();
    check("busy_we_pulses",   32'(we_cnt - we0),     32'd1);
    check("busy_done_pulses", 32'(done_cnt - done0), 32'd1);
    check("busy_mem",         32'(mem[17'h00200]),   32'h00AA55);

    // Reset while a write waits for its slot
    cyc();
    bus.blank = 1'b0; bus.line_start = 1'b1;
    bus.cpu_start = 1'b1; bus.cpu_we = 1'b1;
    bus.cpu_addr = 17'h00300; bus.cpu_data = 24'hDEAD01;
    cyc();
    bus.line_start = 1'b0; bus.cpu_start = 1'b0;
    we0 = we_cnt; done0 = done_cnt;
    reset = 1'b1;
    sample();
    check("rr_we",   32'(bus.ram_we),   32'h0);
    check("rr_busy", 32'(bus.cpu_busy), 32'h0);
    check("rr_done", 32'(bus.cpu_done), 32'h0);
    check("rr_pe_q", 32'(bus.pe_q),     32'h0);
    check("rr_cpu_q", 32'(bus.cpu_q),   32'h0);
    repeat (2) cyc();
    reset = 1'b0;
    repeat (3) cyc();
    check("rr_no_we",   32'(we_cnt - we0),     32'd0);
    check("rr_no_done", 32'(done_cnt - done0), 32'd0);
    check("rr_mem",     32'(mem[17'h00300] === 24'hDEAD01), 32'h0);
    bus.blank = 1'b1;
    cpu_op(1'b1, 17'h00301, 24'hBEEF02, lat);
    check("rr_next_lat", 32'(lat), 32'd2);
    cyc();
    check("rr_next_mem", 32'(mem[17'h00301]), 32'hBEEF02);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got 0x0 expected 0x1");
    $fatal(1, "timeout");
  end

endmodule
